// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array result path.
// Holds collector state encoding and the result row shape.
package systolic_pkg;

  localparam int DEF_MATRIX_SIZE = 2;
  localparam int DEF_DATA_SIZE   = 32;

  typedef enum logic {
    IDLE,
    CAPTURE
  } coll_state_t;

  typedef logic [DEF_DATA_SIZE-1:0] row_t [DEF_MATRIX_SIZE];

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Head is visible on dout the cycle after it is pushed.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // A pop frees the head slot in the same cycle, so full+pop may push.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign dout = empty ? '0 : mem[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_q[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/systolic_result_collector.sv
// Deskews the skewed column stream of the systolic array, assembles
// result rows and buffers them for a valid/ready consumer.
module systolic_result_collector
  import systolic_pkg::*;
#(
  parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
  parameter int DATA_SIZE   = DEF_DATA_SIZE,
  parameter int FIFO_DEPTH  = 4,
  parameter int ROW_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] sum_in [MATRIX_SIZE],
  input  logic                 start,
  input  logic [ROW_CNT_W-1:0] num_rows,
  output logic [DATA_SIZE-1:0] out_row [MATRIX_SIZE],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  localparam int CW = 16;
  localparam int W  = DATA_SIZE * MATRIX_SIZE;

  logic [DATA_SIZE-1:0] aligned [MATRIX_SIZE];
  logic [W-1:0]         row_flat;
  logic [W-1:0]         head_flat;

  // Column j lags column 0 by j cycles; delay it by the remainder.
  for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_col
    localparam int D = MATRIX_SIZE - 1 - j;
    if (D == 0) begin : g_pass
      assign aligned[j] = sum_in[j];
    end else begin : g_dly
      logic [DATA_SIZE-1:0] sr [D];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < D; k++) sr[k] <= '0;
        end else begin
          sr[0] <= sum_in[j];
          for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
        end
      end
      assign aligned[j] = sr[D-1];
    end
    assign row_flat[j*DATA_SIZE +: DATA_SIZE] = aligned[j];
    assign out_row[j] = head_flat[j*DATA_SIZE +: DATA_SIZE];
  end

  coll_state_t          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ROW_CNT_W-1:0] rows_q, rows_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;

  logic [ROW_CNT_W-1:0] nr_eff;
  logic [CW-1:0]        e;
  logic [CW-1:0]        last;
  logic                 start_acc;
  logic                 capturing;
  logic                 push_en;
  logic                 fin;
  logic                 pop;
  logic                 full;
  logic                 empty;

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign busy      = (state_q == CAPTURE);
  assign done      = done_q;
  assign overflow  = ovf_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rows_d    = rows_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    start_acc = (state_q == IDLE) && start;
    nr_eff    = (state_q == IDLE) ? num_rows : rows_q;
    e         = (state_q == IDLE) ? '0 : cnt_q;
    last      = CW'(nr_eff) + CW'(MATRIX_SIZE - 2);
    capturing = (state_q == CAPTURE) ||
                (start_acc && (num_rows != '0));
    push_en   = capturing &&
                (e >= CW'(MATRIX_SIZE - 1)) && (e <= last);
    fin       = capturing && (e == last);

    if (start_acc) begin
      rows_d = num_rows;
      cnt_d  = CW'(1);
      ovf_d  = 1'b0;
    end else if (state_q == CAPTURE) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (capturing) state_d = fin ? IDLE : CAPTURE;

    done_d = fin || (start_acc && (num_rows == '0));

    if (push_en && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rows_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rows_q  <= rows_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_en),
    .pop   (pop),
    .din   (row_flat),
    .dout  (head_flat),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_systolic_result_collector.sv
// Directed bench for systolic_result_collector (M=2, 32-bit, FIFO depth 2).
// Step numbers in names are elapsed cycles since the batch start.
module tb_systolic_result_collector;

  localparam int M  = 2;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] sum_in [M];
  logic          start;
  logic [7:0]    num_rows;
  logic [DW-1:0] out_row [M];
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          overflow;

  int checks   = 0;
  int failures = 0;

  systolic_result_collector #(
    .MATRIX_SIZE (M),
    .DATA_SIZE   (DW),
    .FIFO_DEPTH  (2),
    .ROW_CNT_W   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sum_in    (sum_in),
    .start     (start),
    .num_rows  (num_rows),
    .out_row   (out_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic s(input logic [DW-1:0] c0, input logic [DW-1:0] c1);
    sum_in[0] = c0;
    sum_in[1] = c1;
  endtask

  function automatic logic [63:0] rv(input logic [31:0] c0,
                                     input logic [31:0] c1);
    return {c1, c0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_row(input string tag, input logic [63:0] exp);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_row"}, {out_row[1], out_row[0]}, exp);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_row"}, {out_row[1], out_row[0]}, 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    num_rows = '0;
    out_ready = 1'b1;
    s(0, 0);
    tick();
    tick();
    chk_empty("rst");
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);
    reset = 1'b0;
    tick();

    // Basic two-row batch
    start = 1'b1; num_rows = 8'd2; s(10, 0);
    chk("b0_busy", {63'd0, busy}, 64'd0);
    tick();
    start = 1'b0; s(20, 11);
    chk("b1_busy", {63'd0, busy}, 64'd1);
    chk("b1_valid", {63'd0, out_valid}, 64'd0);
    tick();
    s(0, 21);
    chk_row("b2", rv(10, 11));
    chk("b2_done", {63'd0, done}, 64'd0);
    tick();
    s(0, 0);
    chk_row("b3", rv(20, 21));
    chk("b3_done", {63'd0, done}, 64'd1);
    chk("b3_busy", {63'd0, busy}, 64'd0);
    chk("b3_ovf", {63'd0, overflow}, 64'd0);
    tick();
    chk_empty("b4");
    chk("b4_done", {63'd0, done}, 64'd0);

    // Backpressure: third row dropped
    out_ready = 1'b0;
    start = 1'b1; num_rows = 8'd3; s(1, 0);
    tick();
    start = 1'b0; s(3, 2);
    tick();
    s(5, 4);
    chk_row("o2", rv(1, 2));
    tick();
    s(0, 6);
    chk("o3_ovf", {63'd0, overflow}, 64'd0);
    tick();
    s(0, 0);
    chk("o4_ovf", {63'd0, overflow}, 64'd1);
    chk("o4_done", {63'd0, done}, 64'd1);
    chk_row("o4", rv(1, 2));
    out_ready = 1'b1;
    tick();
    chk_row("o5", rv(3, 4));
    tick();
    chk_empty("o6");
    chk("o6_ovf", {63'd0, overflow}, 64'd1);

    // Full FIFO with pop on the push cycle; start clears overflow
    out_ready = 1'b0;
    start = 1'b1; num_rows = 8'd3; s(7, 0);
    chk("f0_ovf", {63'd0, overflow}, 64'd1);
    tick();
    start = 1'b0; s(9, 8);
    chk("f1_ovf", {63'd0, overflow}, 64'd0);
    tick();
    s(11, 10);
    chk_row("f2", rv(7, 8));
    tick();
    s(0, 12);
    out_ready = 1'b1;
    chk_row("f3", rv(7, 8));
    tick();
    s(0, 0);
    chk_row("f4", rv(9, 10));
    chk("f4_ovf", {63'd0, overflow}, 64'd0);
    chk("f4_done", {63'd0, done}, 64'd1);
    tick();
    chk_row("f5", rv(11, 12));
    tick();
    chk_empty("f6");

    // Leave one row buffered, then reset mid-capture
    out_ready = 1'b0;
    start = 1'b1; num_rows = 8'd1; s(32'h55, 0);
    tick();
    start = 1'b0; s(0, 32'h66);
    tick();
    s(0, 0);
    chk_row("p2", rv(32'h55, 32'h66));
    chk("p2_done", {63'd0, done}, 64'd1);
    start = 1'b1; num_rows = 8'd4; s(1, 0);
    tick();
    start = 1'b0; reset = 1'b1; s(2, 1);
    chk("r1_busy", {63'd0, busy}, 64'd1);
    tick();
    reset = 1'b0; s(0, 0);
    chk_empty("r2");
    chk("r2_busy", {63'd0, busy}, 64'd0);
    chk("r2_done", {63'd0, done}, 64'd0);
    tick();
    out_ready = 1'b1;
    start = 1'b1; num_rows = 8'd1; s(32'hA, 0);
    tick();
    start = 1'b0; s(0, 32'hB);
    tick();
    s(0, 0);
    chk_row("n2", rv(32'hA, 32'hB));
    chk("n2_done", {63'd0, done}, 64'd1);
    tick();
    chk_empty("n3");

    // Start during capture is ignored
    start = 1'b1; num_rows = 8'd2; s(21, 0);
    tick();
    num_rows = 8'd5; s(23, 22);
    tick();
    start = 1'b0; s(0, 24);
    chk_row("i2", rv(21, 22));
    tick();
    s(0, 0);
    chk_row("i3", rv(23, 24));
    chk("i3_done", {63'd0, done}, 64'd1);
    chk("i3_busy", {63'd0, busy}, 64'd0);
    tick();
    chk_empty("i4");
    chk("i4_busy", {63'd0, busy}, 64'd0);

    // Zero-row batch
    start = 1'b1; num_rows = 8'd0;
    tick();
    start = 1'b0;
    chk("z1_done", {63'd0, done}, 64'd1);
    chk("z1_busy", {63'd0, busy}, 64'd0);
    chk_empty("z1");
    tick();
    chk("z2_done", {63'd0, done}, 64'd0);
    chk_empty("z2");

    // Back-to-back batches
    start = 1'b1; num_rows = 8'd2; s(31, 0);
    tick();
    start = 1'b0; s(33, 32);
    tick();
    s(0, 34);
    chk_row("k2", rv(31, 32));
    tick();
    s(0, 0);
    chk_row("k3", rv(33, 34));
    chk("k3_done", {63'd0, done}, 64'd1);
    tick();
    start = 1'b1; num_rows = 8'd2; s(41, 0);
    chk("k4_valid", {63'd0, out_valid}, 64'd0);
    tick();
    start = 1'b0; s(43, 42);
    chk("k5_busy", {63'd0, busy}, 64'd1);
    tick();
    s(0, 44);
    chk_row("k6", rv(41, 42));
    tick();
    s(0, 0);
    chk_row("k7", rv(43, 44));
    chk("k7_done", {63'd0, done}, 64'd1);
    tick();
    chk_empty("k8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
